// File: rtl/sdram_burst_sched.sv
// Burst scheduler above sdram_top: round-robin between write and read bursts,
// keeps the SDRAM write/read pointers as a circular buffer with an occupancy count.
module sdram_burst_sched #(
   parameter int BURST_LEN = 8,
   parameter int FIFO_AW   = 10,
   parameter int ADDR_W    = 22,
   parameter int TIMEOUT   = 4095
) (
   input  logic               s_clk,
   input  logic               s_rst,
   input  logic               init_done,
   input  logic [FIFO_AW-1:0] wfifo_usedw,
   input  logic [FIFO_AW-1:0] rfifo_usedw,
   input  logic               rd_allow,
   input  logic               wr_done,
   input  logic               rd_done,
   output logic               wr_tring,
   output logic               rd_tring,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [ADDR_W:0]    stored,
   output logic               busy,
   output logic               timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [ADDR_W:0]    CAP      = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]    BURST_S  = (ADDR_W + 1)'(BURST_LEN);
   localparam logic [ADDR_W:0]    FULL_LIM = CAP - BURST_S;
   localparam logic [ADDR_W-1:0]  BURST_A  = ADDR_W'(BURST_LEN);
   localparam logic [FIFO_AW-1:0] BURST_F  = FIFO_AW'(BURST_LEN);
   localparam logic [FIFO_AW-1:0] RF_LIM   = {FIFO_AW{1'b1}} - BURST_F;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ARB, WR_WAIT, RD_WAIT} state_t;
   typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

   state_t            state, state_nxt;
   grant_t            last_grant, last_grant_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic              wr_tring_nxt, rd_tring_nxt, timeout_err_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;
   logic [ADDR_W:0]   stored_nxt;
   logic              wr_ok, rd_ok;

   assign wr_ok = (wfifo_usedw >= BURST_F) && (stored <= FULL_LIM);
   assign rd_ok = rd_allow && (stored >= BURST_S) && (rfifo_usedw <= RF_LIM);
   assign busy  = (state == WR_WAIT) || (state == RD_WAIT);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_nxt       = state;
      last_grant_nxt  = last_grant;
      wait_cnt_nxt    = wait_cnt;
      wr_tring_nxt    = 1'b0;
      rd_tring_nxt    = 1'b0;
      timeout_err_nxt = timeout_err;
      wr_addr_nxt     = wr_addr;
      rd_addr_nxt     = rd_addr;
      stored_nxt      = stored;

      unique case (state)
         IDLE: begin
            if (init_done) state_nxt = ARB;
         end
         ARB: begin
            wait_cnt_nxt = '0;
            // last_grant only moves when both sides competed for the slot.
            if (wr_ok && (!rd_ok || last_grant == GRANT_RD)) begin
               state_nxt    = WR_WAIT;
               wr_tring_nxt = 1'b1;
               if (rd_ok) last_grant_nxt = GRANT_WR;
            end else if (rd_ok) begin
               state_nxt    = RD_WAIT;
               rd_tring_nxt = 1'b1;
               if (wr_ok) last_grant_nxt = GRANT_RD;
            end
         end
         WR_WAIT: begin
            if (wr_done) begin
               wr_addr_nxt = wr_addr + BURST_A;
               stored_nxt  = stored + BURST_S;
               state_nxt   = ARB;
            end else if (wait_cnt == CNT_LAST) begin
               timeout_err_nxt = 1'b1;
               state_nxt       = ARB;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         RD_WAIT: begin
            if (rd_done) begin
               rd_addr_nxt = rd_addr + BURST_A;
               stored_nxt  = stored - BURST_S;
               state_nxt   = ARB;
            end else if (wait_cnt == CNT_LAST) begin
               timeout_err_nxt = 1'b1;
               state_nxt       = ARB;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state       <= IDLE;
         last_grant  <= GRANT_RD;
         wait_cnt    <= '0;
         wr_tring    <= 1'b0;
         rd_tring    <= 1'b0;
         timeout_err <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         stored      <= '0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         wait_cnt    <= wait_cnt_nxt;
         wr_tring    <= wr_tring_nxt;
         rd_tring    <= rd_tring_nxt;
         timeout_err <= timeout_err_nxt;
         wr_addr     <= wr_addr_nxt;
         rd_addr     <= rd_addr_nxt;
         stored      <= stored_nxt;
      end
   end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench for sdram_burst_sched: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_sdram_burst_sched;

   localparam int BL     = 8;
   localparam int FAW    = 10;
   localparam int AW     = 6;
   localparam int TO     = 15;
   localparam int CAP    = 1 << AW;
   localparam int RF_LIM = (1 << FAW) - 1 - BL;

   logic           s_clk = 1'b0;
   logic           s_rst, init_done, rd_allow, wr_done, rd_done;
   logic [FAW-1:0] wfifo_usedw, rfifo_usedw;
   logic           wr_tring, rd_tring, busy, timeout_err;
   logic [AW-1:0]  wr_addr, rd_addr;
   logic [AW:0]    stored;

   int vectors     = 0;
   int miscompares = 0;

   always #5 s_clk = ~s_clk;

   sdram_burst_sched #(
      .BURST_LEN(BL), .FIFO_AW(FAW), .ADDR_W(AW), .TIMEOUT(TO)
   ) dut (
      .s_clk(s_clk), .s_rst(s_rst), .init_done(init_done),
      .wfifo_usedw(wfifo_usedw), .rfifo_usedw(rfifo_usedw),
      .rd_allow(rd_allow), .wr_done(wr_done), .rd_done(rd_done),
      .wr_tring(wr_tring), .rd_tring(rd_tring),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .stored(stored),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Reference model: one outstanding burst, circular pointers as integers.
   bit m_started;
   int m_pending;      // 0 = no burst in flight, 1 = write burst, 2 = read burst
   int m_waited;
   int m_wr_ptr, m_rd_ptr, m_stored;
   bit m_err, m_wr_trig, m_rd_trig;
   bit m_tie_to_rd;    // who wins the next contested slot

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_edge();
      bit w, r, go_rd, done;
      m_wr_trig = 1'b0;
      m_rd_trig = 1'b0;
      if (s_rst) begin
         m_started = 0; m_pending = 0; m_waited = 0;
         m_wr_ptr = 0; m_rd_ptr = 0; m_stored = 0;
         m_err = 0; m_tie_to_rd = 0;
         return;
      end
      if (!m_started) begin
         m_started = init_done;
      end else if (m_pending == 0) begin
         w = (int'(wfifo_usedw) >= BL) && (m_stored <= CAP - BL);
         r = rd_allow && (m_stored >= BL) && (int'(rfifo_usedw) <= RF_LIM);
         if (w && r) begin
            go_rd = m_tie_to_rd;
            m_tie_to_rd = !m_tie_to_rd;
         end else begin
            go_rd = r;
         end
         if (w || r) begin
            m_pending = go_rd ? 2 : 1;
            m_waited  = 0;
            if (go_rd) m_rd_trig = 1'b1;
            else       m_wr_trig = 1'b1;
         end
      end else begin
         done = (m_pending == 1) ? wr_done : rd_done;
         if (done) begin
            if (m_pending == 1) begin
               m_wr_ptr = (m_wr_ptr + BL) % CAP;
               m_stored += BL;
            end else begin
               m_rd_ptr = (m_rd_ptr + BL) % CAP;
               m_stored -= BL;
            end
            m_pending = 0;
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               m_err     = 1'b1;
               m_pending = 0;
            end
         end
      end
   endfunction

   task automatic compare();
      int  diff;
      bit  inv_ok;
      check("wr_tring", wr_tring, m_wr_trig);
      check("rd_tring", rd_tring, m_rd_trig);
      check("wr_addr", wr_addr, m_wr_ptr);
      check("rd_addr", rd_addr, m_rd_ptr);
      check("stored", stored, m_stored);
      check("busy", busy, m_pending != 0);
      check("timeout_err", timeout_err, m_err);
      diff   = (int'(wr_addr) - int'(rd_addr) + CAP) % CAP;
      inv_ok = (int'(stored) == diff) || (int'(stored) == CAP && wr_addr == rd_addr);
      check("invariant", inv_ok, 1);
   endtask

   task automatic step();
      @(posedge s_clk);
      model_edge();
      @(negedge s_clk);
      compare();
   endtask

   task automatic do_reset();
      s_rst = 1'b1; wr_done = 1'b0; rd_done = 1'b0;
      step();
      s_rst = 1'b0;
   endtask

   task automatic wait_trig(input int budget, output bit is_rd);
      is_rd = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (wr_tring || rd_tring) break;
      end
      check("trig_seen", wr_tring | rd_tring, 1);
      is_rd = rd_tring;
   endtask

   task automatic finish_burst(input bit is_rd);
      if (is_rd) rd_done = 1'b1;
      else       wr_done = 1'b1;
      step();
      wr_done = 1'b0; rd_done = 1'b0;
   endtask

   initial begin
      bit is_rd;
      int n, n_w, n_r;
      bit exp_rd [7] = '{0, 0, 1, 0, 1, 0, 1};

      s_rst = 1'b1; init_done = 1'b0; rd_allow = 1'b0;
      wr_done = 1'b0; rd_done = 1'b0;
      wfifo_usedw = '0; rfifo_usedw = '0;
      step();
      step();
      check("rst_wr_tring", wr_tring, 0);
      check("rst_stored", stored, 0);
      check("rst_busy", busy, 0);

      // 1: no trigger before init, then wr_tring 2 cycles after init_done
      s_rst = 1'b0; wfifo_usedw = FAW'(20);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (wr_tring || rd_tring) n++;
      end
      check("t1_no_trig_pre_init", n, 0);
      init_done = 1'b1;
      step();
      check("t1_trig_plus1", wr_tring, 0);
      step();
      check("t1_trig_plus2", wr_tring, 1);
      check("t1_wr_addr_at_trig", wr_addr, 0);
      finish_burst(1'b0);
      check("t1_wr_addr_after", wr_addr, 8);
      check("t1_stored_after", stored, 8);

      // 2: round-robin order W W R W R W R with done 10 cycles after each trigger
      do_reset();
      wfifo_usedw = FAW'(100); rd_allow = 1'b1; rfifo_usedw = '0;
      n_w = 0; n_r = 0;
      for (int i = 0; i < 7; i++) begin
         wait_trig(20, is_rd);
         check("t2_is_read", is_rd, exp_rd[i]);
         if (is_rd) begin
            check("t2_rd_addr", rd_addr, n_r * BL);
            n_r++;
         end else begin
            check("t2_wr_addr", wr_addr, n_w * BL);
            n_w++;
         end
         for (int k = 0; k < 9; k++) step();
         finish_burst(is_rd);
      end

      // 3: fill to capacity (pointer wrap), no write when full, drain to empty
      do_reset();
      rd_allow = 1'b0;
      for (int i = 0; i < CAP / BL; i++) begin
         wait_trig(10, is_rd);
         finish_burst(is_rd);
      end
      check("t3_full_stored", stored, CAP);
      check("t3_full_wr_addr", wr_addr, 0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (wr_tring) n++;
      end
      check("t3_no_wr_when_full", n, 0);
      wfifo_usedw = '0; rd_allow = 1'b1;
      for (int i = 0; i < CAP / BL; i++) begin
         wait_trig(10, is_rd);
         finish_burst(is_rd);
      end
      check("t3_empty_stored", stored, 0);
      check("t3_empty_rd_addr", rd_addr, 0);

      // 4: read FIFO free-space threshold
      do_reset();
      wfifo_usedw = FAW'(100); rd_allow = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_trig(10, is_rd);
         finish_burst(is_rd);
      end
      wfifo_usedw = '0; rd_allow = 1'b1; rfifo_usedw = FAW'(1016);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (rd_tring) n++;
      end
      check("t4_no_rd_free7", n, 0);
      rfifo_usedw = FAW'(1015);
      for (int i = 0; i < 2; i++) begin
         step();
         if (rd_tring) break;
      end
      check("t4_rd_fires", rd_tring, 1);
      finish_burst(1'b1);
      rfifo_usedw = '0;

      // 5: timeout after TO wait cycles, spurious rd_done, late wr_done in ARB
      do_reset();
      wfifo_usedw = FAW'(100); rd_allow = 1'b0;
      wait_trig(10, is_rd);
      for (int k = 1; k <= TO; k++) begin
         rd_done = (k == 5);
         step();
         if (k == TO - 1) check("t5_err_before", timeout_err, 0);
      end
      rd_done = 1'b0;
      check("t5_err_set", timeout_err, 1);
      check("t5_wr_addr_kept", wr_addr, 0);
      check("t5_busy_low", busy, 0);
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
      check("t5_retrigger", wr_tring, 1);
      check("t5_late_done_ignored", stored, 0);
      finish_burst(1'b0);
      check("t5_wr_addr_after", wr_addr, 8);
      check("t5_err_sticky", timeout_err, 1);

      // 6: reset during RD_WAIT with a simultaneous rd_done
      do_reset();
      wfifo_usedw = FAW'(100); rd_allow = 1'b0;
      wait_trig(10, is_rd);
      finish_burst(is_rd);
      wfifo_usedw = '0; rd_allow = 1'b1;
      wait_trig(10, is_rd);
      step();
      s_rst = 1'b1; rd_done = 1'b1;
      step();
      s_rst = 1'b0; rd_done = 1'b0;
      check("t6_stored", stored, 0);
      check("t6_wr_addr", wr_addr, 0);
      check("t6_rd_addr", rd_addr, 0);
      check("t6_busy", busy, 0);
      check("t6_tring", wr_tring | rd_tring, 0);

      // Random traffic, including mid-run resets and init_done glitches
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         s_rst       = ($urandom_range(0, 399) == 0);
         init_done   = ($urandom_range(0, 19) != 0);
         rd_allow    = ($urandom_range(0, 3) != 0);
         wr_done     = ($urandom_range(0, 5) == 0);
         rd_done     = ($urandom_range(0, 5) == 0);
         wfifo_usedw = FAW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 9)
                                                        : $urandom_range(0, 1023));
         rfifo_usedw = FAW'(($urandom_range(0, 1) == 0) ? $urandom_range(1010, 1020)
                                                        : $urandom_range(0, 1023));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdram_burst_sched.md
Name: sdram_burst_sched

Overview:
- Burst scheduler that sits above sdram_top.
- Watches the host-side write FIFO and read FIFO levels and decides when to fire wr_tring and rd_tring.
- Shares the SDRAM between the write and read streams using round-robin, and keeps the SDRAM write/read pointers as a circular buffer.
- Does not issue SDRAM commands itself; refresh priority stays inside sdram_top.

Parameters:
- BURST_LEN, 8: words per triggered burst; must be a power of 2.
- FIFO_AW, 10: width of the FIFO usedw count inputs.
- ADDR_W, 22: SDRAM word address width, {bank[1:0], row[11:0], col[7:0]}.
- TIMEOUT, 4095: maximum cycles to wait for a done pulse before aborting the burst.

Ports:
- s_clk  in  1  system clock; all logic is on the rising edge.
- s_rst  in  1  synchronous, active-high reset.
- init_done  in  1  SDRAM initialisation complete (flag_init_end); level signal.
- wfifo_usedw  in  FIFO_AW  words currently in the write FIFO.
- rfifo_usedw  in  FIFO_AW  words currently in the read FIFO.
- rd_allow  in  1  host permits reads to be scheduled.
- wr_done  in  1  one-cycle pulse: the write burst has finished.
- rd_done  in  1  one-cycle pulse: the read burst has finished.
- wr_tring  out  1  one-cycle write-burst trigger.
- rd_tring  out  1  one-cycle read-burst trigger.
- wr_addr  out  ADDR_W  start address of the current or next write burst.
- rd_addr  out  ADDR_W  start address of the current or next read burst.
- stored  out  ADDR_W+1  words held in SDRAM that have not yet been read.
- busy  out  1  high in WR_WAIT and RD_WAIT.
- timeout_err  out  1  sticky error flag; cleared only by s_rst.

Behaviour:
- Reset values: all outputs 0; state = IDLE; last_grant = RD, so the first grant goes to write.
- Capacity: CAP = 2^ADDR_W words.
- Eligibility, evaluated combinationally in ARB:
  - wr_ok = (wfifo_usedw >= BURST_LEN) && (stored <= CAP - BURST_LEN).
  - rd_ok = rd_allow && (stored >= BURST_LEN) && (rfifo_usedw <= 2^FIFO_AW - 1 - BURST_LEN).
- States:
  - IDLE: go to ARB on the first cycle init_done = 1.
  - ARB, if only wr_ok: go to WR_WAIT and assert wr_tring for this one cycle.
  - ARB, if only rd_ok: go to RD_WAIT and assert rd_tring for this one cycle.
  - ARB, if both: grant the side opposite last_grant, then update last_grant.
  - ARB, if neither: stay in ARB.
  - WR_WAIT on wr_done:
    - wr_addr += BURST_LEN, modulo CAP, wrapping to 0 naturally.
    - stored += BURST_LEN.
    - Return to ARB.
  - RD_WAIT on rd_done: rd_addr += BURST_LEN modulo CAP; stored -= BURST_LEN; return to ARB.
- Triggers are registered outputs, high for exactly the one cycle after the ARB decision edge. A new trigger is never issued before the matching done pulse (one outstanding burst at most).
- ARB is held for at least 1 cycle between bursts; done-to-next-trigger latency is 2 cycles.
- Wait-state timeout:
  - A wait counter resets to 0 on entering WR_WAIT or RD_WAIT.
  - If it reaches TIMEOUT without a done pulse: set timeout_err, leave the pointers and stored unchanged, return to ARB.
- Spurious pulses: a done pulse in a state other than its matching WAIT state is ignored, including rd_done in WR_WAIT.
- Both done pulses in the same cycle: only the one matching the current state takes effect.
- init_done falling while not in IDLE: ignored; only s_rst returns the block to IDLE.
- Reset asserted mid-burst:
  - All state clears on the next edge.
  - Triggers drop the same edge.
  - Pointers and stored return to 0; SDRAM contents are treated as discarded.
- Invariant: stored == (wr_addr - rd_addr) mod CAP, except stored == CAP when full with equal pointers. The bench checks this every cycle.

Test Plan:
1. Hold init_done = 0 for 200 cycles with wfifo_usedw = 20 -> no trigger. Raise init_done -> wr_tring pulses exactly 2 cycles later with wr_addr = 0. Pulse wr_done -> wr_addr = 8, stored = 8.
2. Hold wfifo_usedw = 100, rd_allow = 1, rfifo_usedw = 0, and return done 10 cycles after each trigger -> triggers alternate W, W (first read needs stored >= 8), then R, W, R, W...; rd_addr advances 0, 8, 16.
3. Preload wr_addr = rd_addr = CAP - 8 using a reduced ADDR_W = 6 build -> after one write and one read, both pointers = 0 and stored = 0. With stored = 64 = CAP, no wr_tring is issued even with a full wfifo.
4. Set rfifo_usedw = 1016 (free 7 < 8) with stored = 16 -> no rd_tring. Drop rfifo_usedw to 1015 -> rd_tring pulses within 2 cycles.
5. Withhold wr_done after a trigger, using a TIMEOUT = 15 build -> timeout_err = 1 on cycle 15, wr_addr unchanged, state back to ARB, next trigger issued. A late wr_done in ARB -> ignored.
6. Assert s_rst during RD_WAIT -> the next edge gives all outputs 0 and state IDLE. A simultaneous rd_done has no effect.
